int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VBASE, default 8'h00, base interrupt vector; SHALL have low bits [3:1] zero.
REQ-002 Port clk_sys  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port m1_n, iorq_n  input  1 each  Z80 bus strobes; INTA = ~m1_n & ~iorq_n.
REQ-005 Port src_n  input  4  active-low request levels: [0]=kb, [1]=fire, [2]=adc, [3]=vdp.
REQ-006 Port wr_stb  input  1  one-cycle mask-write strobe.
REQ-007 Port wr_sel  input  2  source index for the mask write.
REQ-008 Port wr_data  input  1  mask value; 1=masked.
REQ-009 Port clr  input  4  per-source pending clear (e.g. keyboard read), one cycle.
REQ-010 Port reti  input  1  one-cycle RETI-decoded pulse.
REQ-011 Port iei  input  1  daisy-chain enable in, active-high.
REQ-012 Port int_n  output  1  CPU interrupt request, active-low.
REQ-013 Port vect  output  8  interrupt vector.
REQ-014 Port vect_oe  output  1  high while vect is driven onto the data bus.
REQ-015 Port ieo  output  1  daisy-chain enable out, to CTC IEI.
REQ-016 Port pending  output  4  latched pending flags.
REQ-017 Port in_service  output  4  one-hot source under service.

Function
REQ-018 Edge detect: register src_n each cycle; a 1->0 transition SHALL set pending[i] in the following cycle.
REQ-019 pending[i] SHALL clear on clr[i], or on INTA acknowledge of source i; a set and a clear in the same cycle SHALL leave pending set.
REQ-020 mask[i] SHALL load wr_data when wr_stb & wr_sel==i; masked sources keep pending but SHALL NOT request.
REQ-021 Eligible = pending & ~mask; priority: index 0 highest, 3 lowest.
REQ-022 FSM states: IDLE, REQ, ACK, SERVICE.
REQ-023 IDLE -> REQ when iei=1 and any source eligible; int_n=0 in REQ.
REQ-024 Latency: src_n falls at cycle N -> pending=1 at N+1 -> int_n=0 at N+2.
REQ-025 REQ -> IDLE, int_n=1 next cycle, if iei falls or eligible becomes empty (mask write/clr).
REQ-026 REQ -> ACK on the first cycle INTA is high; idx SHALL latch the highest eligible source at that cycle.
REQ-027 ACK: vect = VBASE | {idx,1'b0}; vect_oe=1 while INTA high; pending[idx] clears; in_service[idx] set; int_n=1.
REQ-028 ACK -> SERVICE when INTA deasserts.
REQ-029 SERVICE: ieo=0; no new request issued; new edges still latch into pending.
REQ-030 SERVICE -> IDLE on reti; in_service clears that cycle; re-request per REQ-023 next cycle.
REQ-031 ieo = iei & (state != SERVICE) & (state != REQ) & (state != ACK).
REQ-032 vect SHALL hold its last value when vect_oe=0; INTA in IDLE or SERVICE SHALL NOT assert vect_oe.

Reset
REQ-033 On reset: state=IDLE, int_n=1, vect=VBASE, vect_oe=0, ieo=iei, pending=0, in_service=0, mask=4'b1111, edge registers=4'b1111.
REQ-034 Reset asserted mid-operation (any state) SHALL abandon service immediately; no vector driven after reset.

Verification
REQ-035 Unmask kb, pulse src_n[0] low at N -> int_n=0 at N+2; INTA -> vect=8'h00, vect_oe=1; reti -> in_service=0, ieo=1.
REQ-036 src_n[3] and src_n[1] fall same cycle, both unmasked, VBASE=8'hF0 -> first vect=8'hF2; after reti, second INTA vect=8'hF6.
REQ-037 Masked adc edge -> pending[2]=1, int_n stays 1; unmask -> int_n=0 two cycles later.
REQ-038 In REQ, drop iei -> int_n=1 next cycle, ieo=0; raise iei -> int_n=0 again.
REQ-039 In SERVICE, new kb edge -> pending[0]=1, int_n=1 until reti, then int_n=0.
REQ-040 Assert reset during ACK -> vect_oe=0, int_n=1, mask=4'b1111, pending=0.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Bus bundle between the interrupt controller and its CPU/peripheral side.
// master = the side that drives strobes and requests, slave = int_ctrl.
interface int_ctrl_if;
  logic       m1_n;
  logic       iorq_n;
  logic [3:0] src_n;
  logic       wr_stb;
  logic [1:0] wr_sel;
  logic       wr_data;
  logic [3:0] clr;
  logic       reti;
  logic       iei;
  logic       int_n;
  logic [7:0] vect;
  logic       vect_oe;
  logic       ieo;
  logic [3:0] pending;
  logic [3:0] in_service;

  modport master (
    output m1_n, iorq_n, src_n, wr_stb, wr_sel, wr_data, clr, reti, iei,
    input  int_n, vect, vect_oe, ieo, pending, in_service
  );

  modport slave (
    input  m1_n, iorq_n, src_n, wr_stb, wr_sel, wr_data, clr, reti, iei,
    output int_n, vect, vect_oe, ieo, pending, in_service
  );
endinterface

// File: rtl/int_ctrl.sv
// Z80 mode-2 style interrupt controller for four level sources
// (kb, fire, adc, vdp) with edge latching, masking, fixed priority
// and daisy-chain IEI/IEO.
module int_ctrl #(
  parameter logic [7:0] VBASE = 8'h00   // bits [3:1] must be zero
) (
  input  logic        clk_sys,
  input  logic        reset,
  int_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [3:0] src_r;
  logic [3:0] pending_r;
  logic [3:0] mask_r;
  logic [3:0] in_service_r;
  logic [7:0] vect_r;
  logic       int_n_r;

  logic       inta_s;
  logic [3:0] fall_s;
  logic [3:0] eligible_s;
  logic [1:0] top_idx_s;
  logic       ack_take_s;
  logic [3:0] ack_clr_s;

  // Lowest set index wins (kb highest priority); returns 0 when empty.
  function automatic logic [1:0] prio_idx(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign inta_s     = ~bus.m1_n & ~bus.iorq_n;
  assign fall_s     = src_r & ~bus.src_n;
  assign eligible_s = pending_r & ~mask_r;
  assign top_idx_s  = prio_idx(eligible_s);
  assign ack_take_s = (state_r == REQ) && (state_s == ACK);
  assign ack_clr_s  = ack_take_s ? onehot(top_idx_s) : 4'b0000;

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode for the request/acknowledge/service sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.iei && (eligible_s != 4'b0000)) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Losing the chain or the last eligible source withdraws the request
        // even if the CPU has started acknowledging in the same cycle.
        if (!bus.iei || (eligible_s == 4'b0000)) begin
          state_s = IDLE;
        end else if (inta_s) begin
          state_s = ACK;
        end else begin
          state_s = REQ;
        end
      end
      ACK: begin
        if (!inta_s) begin
          state_s = SERVICE;
        end else begin
          state_s = ACK;
        end
      end
      SERVICE: begin
        if (bus.reti) begin
          state_s = IDLE;
        end else begin
          state_s = SERVICE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Edge detector history and pending latch; a new edge beats a clear.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      src_r     <= 4'b1111;
      pending_r <= 4'b0000;
    end else begin
      src_r     <= bus.src_n;
      pending_r <= (pending_r & ~(bus.clr | ack_clr_s)) | fall_s;
    end
  end

  // Per-source mask register, all sources masked out of reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mask_r <= 4'b1111;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wr_stb && (bus.wr_sel == 2'(i))) begin
          mask_r[i] <= bus.wr_data;
        end else begin
          mask_r[i] <= mask_r[i];
        end
      end
    end
  end

  // Service tracking, vector latch and registered request line.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      in_service_r <= 4'b0000;
      vect_r       <= VBASE;
      int_n_r      <= 1'b1;
    end else begin
      int_n_r <= (state_s != REQ);
      if (ack_take_s) begin
        in_service_r <= onehot(top_idx_s);
        vect_r       <= VBASE | {5'b00000, top_idx_s, 1'b0};
      end else if ((state_r == SERVICE) && bus.reti) begin
        in_service_r <= 4'b0000;
      end else begin
        in_service_r <= in_service_r;
      end
    end
  end

  assign bus.int_n      = int_n_r;
  assign bus.vect       = vect_r;
  // Gated directly by INTA so the bus is released in the cycle the CPU lets go.
  assign bus.vect_oe    = (state_r == ACK) & inta_s;
  assign bus.ieo        = bus.iei & (state_r == IDLE);
  assign bus.pending    = pending_r;
  assign bus.in_service = in_service_r;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: a vector table for the basic flow and
// masking, plus hand-written multi-cycle sequences.
module tb_int_ctrl;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  int_ctrl_if bus_a ();
  int_ctrl_if bus_b ();

  int_ctrl #(.VBASE(8'h00)) dut_a (.clk_sys(clk_sys), .reset(reset), .bus(bus_a));
  int_ctrl #(.VBASE(8'hF0)) dut_b (.clk_sys(clk_sys), .reset(reset), .bus(bus_b));

  assign bus_b.m1_n    = bus_a.m1_n;
  assign bus_b.iorq_n  = bus_a.iorq_n;
  assign bus_b.src_n   = bus_a.src_n;
  assign bus_b.wr_stb  = bus_a.wr_stb;
  assign bus_b.wr_sel  = bus_a.wr_sel;
  assign bus_b.wr_data = bus_a.wr_data;
  assign bus_b.clr     = bus_a.clr;
  assign bus_b.reti    = bus_a.reti;
  assign bus_b.iei     = bus_a.iei;

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [3:0] src_n;
    logic       wr_stb;
    logic [1:0] wr_sel;
    logic       wr_data;
    logic [3:0] clr;
    logic       inta;
    logic       reti;
    logic       iei;
    logic       e_int_n;
    logic [3:0] e_pending;
    logic [3:0] e_in_service;
    logic       e_vect_oe;
    logic       e_ieo;
    logic [7:0] e_vect;
  } vec_t;

  vec_t vecs [16];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic quiet();
    bus_a.src_n   = 4'hF;
    bus_a.wr_stb  = 1'b0;
    bus_a.wr_sel  = 2'd0;
    bus_a.wr_data = 1'b0;
    bus_a.clr     = 4'h0;
    bus_a.m1_n    = 1'b1;
    bus_a.iorq_n  = 1'b1;
    bus_a.reti    = 1'b0;
    bus_a.iei     = 1'b1;
  endtask

  task automatic set_inta(input logic on);
    bus_a.m1_n   = ~on;
    bus_a.iorq_n = ~on;
  endtask

  // Pulse kb low for one cycle; leaves the controller in REQ if kb is unmasked.
  task automatic kb_pulse();
    bus_a.src_n = 4'hE;
    tick();
    bus_a.src_n = 4'hF;
    tick();
  endtask

  // INTA cycle, INTA release, then RETI: ends back in IDLE.
  task automatic serve();
    set_inta(1'b1);
    tick();
    set_inta(1'b0);
    tick();
    bus_a.reti = 1'b1;
    tick();
    bus_a.reti = 1'b0;
  endtask

  initial begin
    quiet();

    //            src  ws sel wd clr  ia rt ie | int_n pend  isvc  oe ieo vect
    vecs[0]  = '{4'hF,1'b1,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h0,4'h0,1'b0,1'b1,8'h00};
    vecs[1]  = '{4'hE,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h1,4'h0,1'b0,1'b1,8'h00};
    vecs[2]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b0,4'h1,4'h0,1'b0,1'b0,8'h00};
    vecs[3]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b0,4'h1,4'h0,1'b0,1'b0,8'h00};
    vecs[4]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b1,1'b0,1'b1, 1'b1,4'h0,4'h1,1'b1,1'b0,8'h00};
    vecs[5]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b1,1'b0,1'b1, 1'b1,4'h0,4'h1,1'b1,1'b0,8'h00};
    vecs[6]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h0,4'h1,1'b0,1'b0,8'h00};
    vecs[7]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b1,1'b1, 1'b1,4'h0,4'h0,1'b0,1'b1,8'h00};
    vecs[8]  = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h0,4'h0,1'b0,1'b1,8'h00};
    vecs[9]  = '{4'hB,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h4,4'h0,1'b0,1'b1,8'h00};
    vecs[10] = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h4,4'h0,1'b0,1'b1,8'h00};
    vecs[11] = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h4,4'h0,1'b0,1'b1,8'h00};
    vecs[12] = '{4'hF,1'b1,2'd2,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h4,4'h0,1'b0,1'b1,8'h00};
    vecs[13] = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b0,4'h4,4'h0,1'b0,1'b0,8'h00};
    vecs[14] = '{4'hF,1'b0,2'd0,1'b0,4'h4,1'b0,1'b0,1'b1, 1'b0,4'h0,4'h0,1'b0,1'b0,8'h00};
    vecs[15] = '{4'hF,1'b0,2'd0,1'b0,4'h0,1'b0,1'b0,1'b1, 1'b1,4'h0,4'h0,1'b0,1'b1,8'h00};

    // Reset state
    tick();
    tick();
    chk("rst_int_n",   8'(bus_a.int_n),      8'h01);
    chk("rst_vect_a",  bus_a.vect,           8'h00);
    chk("rst_vect_b",  bus_b.vect,           8'hF0);
    chk("rst_vect_oe", 8'(bus_a.vect_oe),    8'h00);
    chk("rst_ieo",     8'(bus_a.ieo),        8'h01);
    chk("rst_pending", 8'(bus_a.pending),    8'h00);
    chk("rst_insvc",   8'(bus_a.in_service), 8'h00);
    reset = 1'b0;
    tick();

    // Table: kb flow with latency, then masked adc and clr withdrawal
    for (int i = 0; i < 16; i++) begin
      bus_a.src_n   = vecs[i].src_n;
      bus_a.wr_stb  = vecs[i].wr_stb;
      bus_a.wr_sel  = vecs[i].wr_sel;
      bus_a.wr_data = vecs[i].wr_data;
      bus_a.clr     = vecs[i].clr;
      set_inta(vecs[i].inta);
      bus_a.reti    = vecs[i].reti;
      bus_a.iei     = vecs[i].iei;
      tick();
      chk($sformatf("v%0d_int_n", i),   8'(bus_a.int_n),      8'(vecs[i].e_int_n));
      chk($sformatf("v%0d_pending", i), 8'(bus_a.pending),    8'(vecs[i].e_pending));
      chk($sformatf("v%0d_insvc", i),   8'(bus_a.in_service), 8'(vecs[i].e_in_service));
      chk($sformatf("v%0d_vect_oe", i), 8'(bus_a.vect_oe),    8'(vecs[i].e_vect_oe));
      chk($sformatf("v%0d_ieo", i),     8'(bus_a.ieo),        8'(vecs[i].e_ieo));
      chk($sformatf("v%0d_vect", i),    bus_a.vect,           vecs[i].e_vect);
    end
    quiet();

    // iei dropped while requesting
    kb_pulse();
    chk("iei_req_int_n", 8'(bus_a.int_n), 8'h00);
    bus_a.iei = 1'b0;
    tick();
    chk("iei_drop_int_n", 8'(bus_a.int_n), 8'h01);
    chk("iei_drop_ieo",   8'(bus_a.ieo),   8'h00);
    bus_a.iei = 1'b1;
    tick();
    chk("iei_rise_int_n", 8'(bus_a.int_n), 8'h00);
    chk("iei_rise_ieo",   8'(bus_a.ieo),   8'h00);
    serve();
    chk("iei_end_insvc", 8'(bus_a.in_service), 8'h00);

    // New edge during service waits for reti
    kb_pulse();
    set_inta(1'b1);
    tick();
    set_inta(1'b0);
    tick();
    bus_a.src_n = 4'hE;
    tick();
    bus_a.src_n = 4'hF;
    chk("svc_pending", 8'(bus_a.pending), 8'h01);
    chk("svc_int_n",   8'(bus_a.int_n),   8'h01);
    tick();
    chk("svc_int_n2",  8'(bus_a.int_n),   8'h01);
    chk("svc_ieo",     8'(bus_a.ieo),     8'h00);
    bus_a.reti = 1'b1;
    tick();
    bus_a.reti = 1'b0;
    chk("reti_int_n",  8'(bus_a.int_n),      8'h01);
    chk("reti_insvc",  8'(bus_a.in_service), 8'h00);
    chk("reti_ieo",    8'(bus_a.ieo),        8'h01);
    tick();
    chk("rereq_int_n", 8'(bus_a.int_n),      8'h00);
    serve();

    // Simultaneous fire + vdp edges: priority and vector encoding
    bus_a.wr_stb = 1'b1;
    bus_a.wr_sel = 2'd1;
    tick();
    bus_a.wr_sel = 2'd3;
    tick();
    bus_a.wr_stb = 1'b0;
    bus_a.src_n  = 4'h5;
    tick();
    bus_a.src_n  = 4'hF;
    chk("dual_pending", 8'(bus_a.pending), 8'h0A);
    tick();
    chk("dual_int_n", 8'(bus_a.int_n), 8'h00);
    set_inta(1'b1);
    tick();
    chk("ack1_vect_a",  bus_a.vect,           8'h02);
    chk("ack1_vect_b",  bus_b.vect,           8'hF2);
    chk("ack1_oe",      8'(bus_a.vect_oe),    8'h01);
    chk("ack1_insvc",   8'(bus_a.in_service), 8'h02);
    chk("ack1_pending", 8'(bus_a.pending),    8'h08);
    set_inta(1'b0);
    tick();
    bus_a.reti = 1'b1;
    tick();
    bus_a.reti = 1'b0;
    tick();
    chk("dual_rereq_int_n", 8'(bus_a.int_n), 8'h00);
    set_inta(1'b1);
    tick();
    chk("ack2_vect_a",  bus_a.vect,           8'h06);
    chk("ack2_vect_b",  bus_b.vect,           8'hF6);
    chk("ack2_insvc",   8'(bus_a.in_service), 8'h08);
    chk("ack2_pending", 8'(bus_a.pending),    8'h00);
    set_inta(1'b0);
    tick();
    chk("hold_vect_b", bus_b.vect,        8'hF6);
    chk("hold_oe",     8'(bus_b.vect_oe), 8'h00);
    bus_a.reti = 1'b1;
    tick();
    bus_a.reti = 1'b0;
    set_inta(1'b1);
    tick();
    chk("idle_inta_oe", 8'(bus_a.vect_oe), 8'h00);
    set_inta(1'b0);
    tick();

    // Reset during ACK
    kb_pulse();
    set_inta(1'b1);
    tick();
    chk("pre_rst_oe", 8'(bus_a.vect_oe), 8'h01);
    reset = 1'b1;
    #2;
    chk("mid_rst_oe",      8'(bus_a.vect_oe),    8'h00);
    chk("mid_rst_int_n",   8'(bus_a.int_n),      8'h01);
    chk("mid_rst_pending", 8'(bus_a.pending),    8'h00);
    chk("mid_rst_insvc",   8'(bus_a.in_service), 8'h00);
    chk("mid_rst_vect_b",  bus_b.vect,           8'hF0);
    tick();
    set_inta(1'b0);
    reset = 1'b0;
    tick();
    kb_pulse();
    chk("post_rst_pending", 8'(bus_a.pending), 8'h01);
    chk("post_rst_masked",  8'(bus_a.int_n),   8'h01);
    tick();
    chk("post_rst_masked2", 8'(bus_a.int_n),   8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
